// File: rtl/rv32_pipeline_pkg.sv
// Shared pipeline definitions for the RV32 core: LSU state and fault encodings,
// plus the RV32I load/store funct3 width/sign codes.
package rv32_pipeline_pkg;

    // Load/store unit bus sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Fault cause reported alongside the one-cycle lsu_fault pulse
    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_ILLEGAL    = 2'd2,
        FAULT_TIMEOUT    = 2'd3
    } lsu_fault_t;

    // RV32I funct3 codes for loads
    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;

    // RV32I funct3 codes for stores
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane logic for the LSU: byte enables and lane-replicated store
// data for the outgoing request, access legality checks, and extraction plus
// sign/zero extension of the returned load word.
module rv32_lsu_align (
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    import rv32_pipeline_pkg::*;

    logic        load_ok;
    logic        store_ok;
    logic [31:0] shifted;

    // Legality: one direction only, a defined width code, natural alignment
    always_comb begin
        load_ok    = funct3 inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
        store_ok   = funct3 inside {LSU_SB, LSU_SH, LSU_SW};
        illegal    = (is_load && is_store) || (is_load && !load_ok) || (is_store && !store_ok);
        misaligned = ((funct3[1:0] == 2'b10) && (lane != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && lane[0]);
    end

    // Byte enables and store data replicated into every lane the width allows
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << lane;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend per the load type
    always_comb begin
        shifted = rdata >> {ld_lane, 3'b000};
        case (ld_funct3)
            LSU_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_LBU: ld_data = {24'd0, shifted[7:0]};
            LSU_LHU: ld_data = {16'd0, shifted[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32_lsu.sv
// RV32 load/store unit: turns the memory-stage request into a req/gnt/rvalid
// word-bus transaction and stalls the pipeline until it completes.
// Optional feature macro LSU_TIMEOUT_EN: adds a REQ/WAIT cycle counter that
// abandons a transaction after TIMEOUT_CYCLES cycles with FAULT_TIMEOUT.
module rv32_lsu
`ifdef LSU_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_read_en,
    input  logic        lsu_write_en,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_stall,
    output logic        lsu_fault,
    output logic [1:0]  lsu_fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    import rv32_pipeline_pkg::*;

    lsu_state_t  state_p0;
    lsu_state_t  state_nxt;
    lsu_fault_t  cause_c;
    logic [2:0]  ld_funct3_p0;
    logic [1:0]  ld_lane_p0;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ld_data_c;
    logic        misaligned_c;
    logic        illegal_c;
    logic        req_c;
    logic        start_c;
    logic        idle_fault_c;
    logic        complete_c;
    logic        timeout_c;
    logic        to_fault_c;

    rv32_lsu_align u_align (
        .is_load    (lsu_read_en),
        .is_store   (lsu_write_en),
        .funct3     (lsu_funct3),
        .lane       (lsu_addr[1:0]),
        .wdata      (lsu_wdata),
        .be         (be_c),
        .wdata_rep  (wdata_c),
        .misaligned (misaligned_c),
        .illegal    (illegal_c),
        .ld_funct3  (ld_funct3_p0),
        .ld_lane    (ld_lane_p0),
        .rdata      (bus_rdata),
        .ld_data    (ld_data_c)
    );

    assign req_c        = lsu_read_en | lsu_write_en;
    assign idle_fault_c = (state_p0 == IDLE) && req_c && (misaligned_c || illegal_c);
    assign start_c      = (state_p0 == IDLE) && req_c && !(misaligned_c || illegal_c);
    assign complete_c   = ((state_p0 == REQ) && bus_gnt && bus_rvalid) ||
                          ((state_p0 == WAIT) && bus_rvalid);
    assign bus_req      = (state_p0 == REQ);
    assign lsu_stall    = start_c || (state_p0 == REQ) || (state_p0 == WAIT);

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_p0;
    logic        to_flag_p0;

    assign timeout_c  = ((state_p0 == REQ) || (state_p0 == WAIT)) && !complete_c &&
                        (cnt_p0 == TO_LAST);
    assign to_fault_c = (state_p0 == DONE) && to_flag_p0;

    // Count outstanding cycles; remember a timeout so DONE can report it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0     <= 16'd0;
            to_flag_p0 <= 1'b0;
        end else begin
            if (start_c) begin
                cnt_p0 <= 16'd0;
            end else if ((state_p0 == REQ) || (state_p0 == WAIT)) begin
                cnt_p0 <= cnt_p0 + 16'd1;
            end
            if (timeout_c) begin
                to_flag_p0 <= 1'b1;
            end else if (state_p0 == DONE) begin
                to_flag_p0 <= 1'b0;
            end
        end
    end
`else
    assign timeout_c  = 1'b0;
    assign to_fault_c = 1'b0;
`endif

    assign lsu_fault       = idle_fault_c || to_fault_c;
    assign lsu_fault_cause = cause_c;

    // Fault cause: request-check faults in IDLE, timeout reported in DONE
    always_comb begin
        cause_c = FAULT_NONE;
        if (idle_fault_c) begin
            cause_c = illegal_c ? FAULT_ILLEGAL : FAULT_MISALIGNED;
        end else if (to_fault_c) begin
            cause_c = FAULT_TIMEOUT;
        end
    end

    // Next-state logic for the bus handshake sequencer
    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE: if (start_c) state_nxt = REQ;
            REQ: begin
                if (bus_gnt && bus_rvalid) state_nxt = DONE;
                else if (bus_gnt)          state_nxt = WAIT;
            end
            WAIT: if (bus_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timeout_c) state_nxt = DONE;
    end

    // State, latched bus request fields and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0     <= IDLE;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_be       <= 4'd0;
            bus_wdata    <= 32'd0;
            ld_funct3_p0 <= 3'd0;
            ld_lane_p0   <= 2'd0;
            lsu_rdata    <= 32'd0;
        end else begin
            state_p0 <= state_nxt;
            if (start_c) begin
                bus_we       <= lsu_write_en;
                bus_addr     <= {lsu_addr[31:2], 2'b00};
                bus_be       <= be_c;
                bus_wdata    <= wdata_c;
                ld_funct3_p0 <= lsu_funct3;
                ld_lane_p0   <= lsu_addr[1:0];
            end
            if (timeout_c) begin
                lsu_rdata <= 32'd0;
            end else if (complete_c && !bus_we) begin
                lsu_rdata <= ld_data_c;
            end
        end
    end

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed testbench for rv32_lsu: loads/stores of every width, fault checks,
// reset during a transaction and the optional LSU_TIMEOUT_EN behaviour.
module tb_rv32_lsu;
    import rv32_pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_read_en, lsu_write_en;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        lsu_stall, lsu_fault;
    logic [1:0]  lsu_fault_cause;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;

    int          stalls;
    int          req_cycles;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    logic        s_we, s_req;

    always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
    rv32_lsu #(.TIMEOUT_CYCLES(4)) dut (
`else
    rv32_lsu dut (
`endif
        .clk(clk), .rst(rst),
        .lsu_read_en(lsu_read_en), .lsu_write_en(lsu_write_en),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall), .lsu_fault(lsu_fault),
        .lsu_fault_cause(lsu_fault_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        lsu_read_en  = rd;
        lsu_write_en = wr;
        lsu_funct3   = f3;
        lsu_addr     = a;
        lsu_wdata    = wd;
    endtask

    task automatic clear_req();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // IDLE cycle with the request, REQ cycle with gnt&rvalid, ends at the DONE negedge
    task automatic fast_txn(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word);
        next_cycle();
        set_req(rd, wr, f3, a, wd);
        @(negedge clk);
        stalls = int'(lsu_stall);
        next_cycle();
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = word;
        @(negedge clk);
        stalls += int'(lsu_stall);
        s_req = bus_req; s_we = bus_we; s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata;
        next_cycle();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        stalls += int'(lsu_stall);
    endtask

    // Single-cycle request expected to fault in IDLE without touching the bus
    task automatic fault_case(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a, input logic [1:0] cause);
        next_cycle();
        set_req(rd, wr, f3, a, 32'h0);
        @(negedge clk);
        chk({tag, "_fault"}, 32'(lsu_fault), 32'd1);
        chk({tag, "_cause"}, 32'(lsu_fault_cause), 32'(cause));
        chk({tag, "_stall"}, 32'(lsu_stall), 32'd0);
        next_cycle();
        clear_req();
        @(negedge clk);
        chk({tag, "_noreq"}, 32'(bus_req), 32'd0);
        chk({tag, "_pulse"}, 32'(lsu_fault), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        clear_req();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req",   32'(bus_req),   32'd0);
        chk("rst_we",    32'(bus_we),    32'd0);
        chk("rst_addr",  bus_addr,       32'd0);
        chk("rst_be",    32'(bus_be),    32'd0);
        chk("rst_wdata", bus_wdata,      32'd0);
        chk("rst_rdata", lsu_rdata,      32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_fault", 32'(lsu_fault), 32'd0);
        chk("rst_cause", 32'(lsu_fault_cause), 32'd0);

        // LW 0x100: gnt in the first REQ cycle, rvalid two cycles later
        next_cycle();
        set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        @(negedge clk);
        stalls = int'(lsu_stall);
        next_cycle();
        bus_gnt = 1'b1;
        @(negedge clk);
        stalls += int'(lsu_stall);
        chk("lw_req",  32'(bus_req), 32'd1);
        chk("lw_addr", bus_addr,     32'h100);
        chk("lw_be",   32'(bus_be),  32'hF);
        chk("lw_we",   32'(bus_we),  32'd0);
        next_cycle();
        bus_gnt = 1'b0;
        @(negedge clk);
        stalls += int'(lsu_stall);
        chk("lw_wait_req", 32'(bus_req), 32'd0);
        next_cycle();
        bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        stalls += int'(lsu_stall);
        next_cycle();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        chk("lw_done_stall", 32'(lsu_stall), 32'd0);
        chk("lw_rdata",      lsu_rdata,      32'hDEADBEEF);
        chk("lw_stalls",     32'(stalls),    32'd4);
        next_cycle();
        clear_req();
        @(negedge clk);
        chk("lw_noretrig", 32'(bus_req), 32'd0);

        // Byte/half loads with extension
        fast_txn(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFF7F);
        chk("lb_be",    32'(s_be),   32'b1000);
        chk("lb_addr",  s_addr,      32'h200);
        chk("lb_rdata", lsu_rdata,   32'hFFFFFF80);
        fast_txn(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFF7F);
        chk("lbu_rdata", lsu_rdata,  32'h00000080);
        fast_txn(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FFFF7F);
        chk("lhu_be",    32'(s_be),  32'b1100);
        chk("lhu_rdata", lsu_rdata,  32'h000080FF);
        fast_txn(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 32'h12348001);
        chk("lh_rdata",  lsu_rdata,  32'hFFFF8001);
        fast_txn(1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 32'h80FFFF7F);
        chk("lb0_rdata", lsu_rdata,  32'h0000007F);

        // Stores: lane replication, byte enables, minimum latency
        fast_txn(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'hFFFFFFFF);
        chk("sh_req",    32'(s_req),   32'd1);
        chk("sh_we",     32'(s_we),    32'd1);
        chk("sh_addr",   s_addr,       32'h300);
        chk("sh_be",     32'(s_be),    32'b1100);
        chk("sh_wdata",  s_wdata,      32'hABCDABCD);
        chk("sh_stalls", 32'(stalls),  32'd2);
        chk("sh_keep_rdata", lsu_rdata, 32'h0000007F);
        fast_txn(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000005A, 32'h0);
        chk("sb_be",    32'(s_be), 32'b0010);
        chk("sb_wdata", s_wdata,   32'h5A5A5A5A);
        next_cycle();
        clear_req();

        // Request checks that fault in IDLE
        fault_case("lw_mis",  1'b1, 1'b0, 3'b010, 32'h101, FAULT_MISALIGNED);
        fault_case("lh_mis",  1'b1, 1'b0, 3'b001, 32'h201, FAULT_MISALIGNED);
        fault_case("ld_f011", 1'b1, 1'b0, 3'b011, 32'h100, FAULT_ILLEGAL);
        fault_case("st_f100", 1'b0, 1'b1, 3'b100, 32'h100, FAULT_ILLEGAL);
        fault_case("both_en", 1'b1, 1'b1, 3'b010, 32'h100, FAULT_ILLEGAL);

        // Grant withheld: timeout build abandons, default build keeps waiting
        next_cycle();
        set_req(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        req_cycles = 0;
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            if (bus_req) req_cycles++;
        end
        chk("to_req_cycles", 32'(req_cycles),      32'd4);
        chk("to_fault",      32'(lsu_fault),       32'd1);
        chk("to_cause",      32'(lsu_fault_cause), 32'(FAULT_TIMEOUT));
        chk("to_rdata",      lsu_rdata,            32'd0);
        chk("to_stall",      32'(lsu_stall),       32'd0);
        chk("to_req",        32'(bus_req),         32'd0);
        next_cycle();
        clear_req();
        @(negedge clk);
        chk("to_pulse", 32'(lsu_fault), 32'd0);
`else
        for (int i = 0; i < 1000; i++) begin
            next_cycle();
            @(negedge clk);
            if (bus_req && lsu_stall) req_cycles++;
        end
        chk("nto_req_cycles", 32'(req_cycles), 32'd1000);
        chk("nto_fault",      32'(lsu_fault),  32'd0);
        next_cycle();
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        next_cycle();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        chk("nto_rdata", lsu_rdata,      32'hCAFEF00D);
        chk("nto_stall", 32'(lsu_stall), 32'd0);
        next_cycle();
        clear_req();
`endif

        // Reset while waiting for rvalid; the late rvalid must be dropped
        fast_txn(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h11223344);
        chk("pre_rst_rdata", lsu_rdata, 32'h11223344);
        next_cycle();
        set_req(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        next_cycle();
        bus_gnt = 1'b1;
        next_cycle();
        bus_gnt = 1'b0;
        clear_req();
        @(negedge clk);
        chk("rw_wait_stall", 32'(lsu_stall), 32'd1);
        chk("rw_wait_req",   32'(bus_req),   32'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("rw_req",   32'(bus_req),   32'd0);
        chk("rw_stall", 32'(lsu_stall), 32'd0);
        chk("rw_rdata", lsu_rdata,      32'd0);
        next_cycle();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        chk("rw_late_rdata", lsu_rdata,      32'd0);
        chk("rw_late_stall", 32'(lsu_stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_lsu.md
Name: rv32_lsu

Overview:
- Load/store unit directly downstream of the pipeline's memory stage.
- Consumes the memory-stage request (address, store data, read/write enables, funct3).
- Drives a word-addressed data bus with a req/gnt/rvalid handshake.
- Returns aligned, sign/zero-extended load data, plus a stall that holds the pipeline while the bus transaction is outstanding.
- Replaces the direct single-cycle memory hookup so multi-cycle memories and byte/halfword accesses are supported.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ+WAIT before a bus timeout fault. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lsu_read_en  in  1  memory-stage load request
- lsu_write_en  in  1  memory-stage store request
- lsu_funct3  in  3  RV32I load/store width/sign code
- lsu_addr  in  32  byte address (ALU result)
- lsu_wdata  in  32  store data (rs2)
- lsu_rdata  out  32  extended load result
- lsu_stall  out  1  hold pc and all pipeline registers
- lsu_fault  out  1  one-cycle fault pulse
- lsu_fault_cause  out  2  lsu_fault_t code, valid with lsu_fault
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {lsu_addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack (loads and stores)
- bus_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE; bus_req, bus_we 0; bus_addr, bus_be, bus_wdata 0; lsu_rdata 0; lsu_stall 0; lsu_fault 0; cause FAULT_NONE; timeout counter 0.
- Request validity in IDLE:
  - Request = read_en | write_en.
  - Both enables set → FAULT_ILLEGAL.
  - funct3 ∉ {000,001,010,100,101} for loads, or ∉ {000,001,010} for stores → FAULT_ILLEGAL.
  - Word access with addr[1:0]≠0, or half access with addr[0]≠0 → FAULT_MISALIGNED.
  - On any fault: lsu_fault pulses in that same IDLE cycle (combinational), no bus transaction, lsu_stall stays 0, lsu_rdata unchanged.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE + valid request: lsu_stall=1 combinationally; register bus_addr/be/we/wdata; next = REQ.
  - REQ: bus_req=1, bus fields held stable, lsu_stall=1.
    - gnt & rvalid → DONE.
    - gnt only → WAIT.
    - Otherwise stay.
  - WAIT: bus_req=0, lsu_stall=1. rvalid → DONE.
  - DONE: lsu_stall=0; pipeline advances at the end of this cycle; next = IDLE unconditionally. The request inputs still present in DONE never retrigger.
- Load data: captured on rvalid of a read into lsu_rdata, visible in DONE and held until the next completed load.
- Byte enables by lane = addr[1:0]:
  - SB/LB/LBU: 1<<lane.
  - SH/LH/LHU: 4'b0011 << lane.
  - SW/LW: 4'b1111.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extraction: byte/half selected by lane; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- rvalid in IDLE or DONE is ignored. gnt outside REQ is ignored.
- Reset mid-transaction: return to IDLE, drop bus_req; a late rvalid is ignored.
- Minimum latency with gnt & rvalid in the first REQ cycle: stall high 2 cycles, DONE in cycle 3.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on IDLE→REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES forces DONE with lsu_fault=1, cause FAULT_TIMEOUT, lsu_rdata=0, and bus_req dropped.
- Undefined: no counter; the LSU waits indefinitely and FAULT_TIMEOUT is never produced.

Decomposition:
- rv32_pipeline_pkg gains:
  - lsu_state_t enum (IDLE, REQ, WAIT, DONE).
  - lsu_fault_t enum (FAULT_NONE, FAULT_MISALIGNED, FAULT_ILLEGAL, FAULT_TIMEOUT).
  - funct3 constants LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW.
- Sub-module rv32_lsu_align: combinational byte-enable/wdata generation, load lane extraction and extension, misalignment/illegal checks. The FSM and registers stay in rv32_lsu.

Test Plan:
- LW at 0x100, bus gnt next cycle, rvalid 2 cycles later with 0xDEADBEEF → stall high 4 cycles, lsu_rdata=0xDEADBEEF in DONE, bus_be=4'hF, bus_addr=0x100.
- LB at 0x203, rdata 0x80FF_FF7F → lsu_rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x202 → 0x000080FF.
- SH at 0x302, wdata 0x1234ABCD → bus_we=1, bus_addr=0x300, bus_be=4'b1100, bus_wdata=0xABCDABCD. gnt&rvalid in the same cycle → DONE after 2 stall cycles.
- LW at 0x101 → lsu_fault=1, cause FAULT_MISALIGNED, bus_req never asserts, lsu_stall=0. Load funct3=011 → FAULT_ILLEGAL. read_en and write_en both set → FAULT_ILLEGAL.
- rst asserted in WAIT, then rvalid arrives → state IDLE, bus_req=0, lsu_rdata=0, the rvalid is ignored.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt held low → after 4 REQ cycles: DONE, FAULT_TIMEOUT, bus_req dropped. Without the macro → still in REQ after 1000 cycles.
